// File: rtl/pool_pkg.sv
// Shared lane geometry, vector types and lane-wise helpers for the 2x2 pooling stream.
// POOL_AVG_EN widens the stored lanes so the average path can carry partial sums.
package pool_pkg;

  localparam int LANES  = 8;
  localparam int DATA_W = 8;
  localparam int VEC_W  = LANES * DATA_W;
  localparam int SUM_W  = DATA_W + 2;
`ifdef POOL_AVG_EN
  localparam int LB_W   = SUM_W;
`else
  localparam int LB_W   = DATA_W;
`endif

  typedef logic signed [DATA_W-1:0] lane_t;
  typedef logic [VEC_W-1:0]         vec_t;
  typedef logic [LANES*LB_W-1:0]    lb_vec_t;

  function automatic vec_t vec_max(input vec_t a, input vec_t b);
    vec_t  r;
    lane_t la;
    lane_t lb;
    r = '0;
    for (int l = 0; l < LANES; l++) begin
      la = lane_t'(a[l*DATA_W +: DATA_W]);
      lb = lane_t'(b[l*DATA_W +: DATA_W]);
      r[l*DATA_W +: DATA_W] = (la > lb) ? la : lb;
    end
    return r;
  endfunction

  function automatic lb_vec_t to_lb(input vec_t v);
    lb_vec_t r;
    r = '0;
    for (int l = 0; l < LANES; l++)
      r[l*LB_W +: LB_W] = LB_W'(lane_t'(v[l*DATA_W +: DATA_W]));
    return r;
  endfunction

  function automatic vec_t from_lb(input lb_vec_t v);
    vec_t r;
    r = '0;
    for (int l = 0; l < LANES; l++)
      r[l*DATA_W +: DATA_W] = v[l*LB_W +: DATA_W];
    return r;
  endfunction

  function automatic lb_vec_t vec_avg_sum(input lb_vec_t a, input lb_vec_t b);
    lb_vec_t r;
    r = '0;
    for (int l = 0; l < LANES; l++)
      r[l*LB_W +: LB_W] = a[l*LB_W +: LB_W] + b[l*LB_W +: LB_W];
    return r;
  endfunction

  // Four-sample sum to rounded mean: (sum + 2) >>> 2, always back in DATA_W range.
  function automatic vec_t avg_round(input lb_vec_t s);
    vec_t                    r;
    logic signed [LB_W-1:0]  t;
    r = '0;
    for (int l = 0; l < LANES; l++) begin
      t = $signed(s[l*LB_W +: LB_W]) + $signed(LB_W'(2));
      t = t >>> 2;
      r[l*DATA_W +: DATA_W] = t[DATA_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/pool2d_stream_if.sv
// Valid/ready vector stream used on both sides of the pooling engine.
interface pool2d_stream_if #(
  parameter int WIDTH = pool_pkg::VEC_W
) ();
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/pool_line_buffer.sv
// Simple dual-port row store with registered read; a read and write of the same
// address in one cycle returns the previous row's value.
module pool_line_buffer #(
  parameter int DEPTH = 4096,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (re)
      rdata <= mem[raddr];
    if (we)
      mem[waddr] <= wdata;
  end
endmodule

// File: rtl/pool2d_stream.sv
// 2x2 max pooling over a channel-vector-major raster stream, stride 1 or 2.
// Define POOL_AVG_EN to add cfg_avg and the rounded-average datapath.
module pool2d_stream
  import pool_pkg::*;
#(
  parameter int MAX_CH_VEC  = 128,
  parameter int MAX_ROW_VEC = 4096
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [15:0]            cfg_width,
  input  logic [15:0]            cfg_height,
  input  logic [7:0]             cfg_ch_vec,
  input  logic                   cfg_stride2,
`ifdef POOL_AVG_EN
  input  logic                   cfg_avg,
`endif
  pool2d_stream_if.slave         s,
  pool2d_stream_if.master        m,
  output logic                   frame_done
);
  localparam int CW = (MAX_CH_VEC > 1) ? $clog2(MAX_CH_VEC) : 1;
  localparam int PW = $clog2(MAX_ROW_VEC);

  logic          en, acc;
  logic [7:0]    ch;
  logic [15:0]   col, row;
  logic [PW-1:0] ptr;
  logic [23:0]   pitch;
  logic          ch_last, col_last, row_last, ptr_last;
  logic          emit, lb_wr, last_out;
  vec_t          cd_mem [MAX_CH_VEC];
  vec_t          cur, prev, pooled, md;
  lb_vec_t       hval, h1, lb_rdata;
  logic          v1, last1, mv, last2;

  assign en    = !mv || m.ready;
  assign acc   = s.valid && en;
  assign cur   = s.data;
  assign prev  = cd_mem[ch[CW-1:0]];

  assign ch_last  = (ch == cfg_ch_vec - 8'd1);
  assign col_last = (col == cfg_width - 16'd1);
  assign row_last = (row == cfg_height - 16'd1);
  assign pitch    = cfg_stride2 ? 24'(cfg_width >> 1) * 24'(cfg_ch_vec)
                                : 24'(cfg_width - 16'd1) * 24'(cfg_ch_vec);
  assign ptr_last = (24'(ptr) == pitch - 24'd1);

  // Stride 2 drops an odd trailing row/column, so its last window ends on the last even-aligned pair.
  assign emit     = cfg_stride2 ? (row[0] && col[0]) : (row != 16'd0 && col != 16'd0);
  assign lb_wr    = cfg_stride2 ? col[0] : (col != 16'd0);
  assign last_out = emit && ch_last &&
                    (cfg_stride2 ? (row == {cfg_height[15:1], 1'b0} - 16'd1 &&
                                    col == {cfg_width[15:1], 1'b0} - 16'd1)
                                 : (row_last && col_last));

  always_ff @(posedge clk) begin
    if (rst) begin
      ch  <= 8'd0;
      col <= 16'd0;
      row <= 16'd0;
      ptr <= '0;
    end else if (acc) begin
      ch <= ch_last ? 8'd0 : ch + 8'd1;
      if (ch_last) begin
        col <= col_last ? 16'd0 : col + 16'd1;
        if (col_last)
          row <= row_last ? 16'd0 : row + 16'd1;
      end
      if (lb_wr)
        ptr <= ptr_last ? '0 : ptr + PW'(1);
      if (ch_last && col_last && row_last)
        ptr <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (acc)
      cd_mem[ch[CW-1:0]] <= cur;
  end

`ifdef POOL_AVG_EN
  assign hval   = cfg_avg ? vec_avg_sum(to_lb(cur), to_lb(prev)) : to_lb(vec_max(cur, prev));
  assign pooled = cfg_avg ? avg_round(vec_avg_sum(h1, lb_rdata))
                          : vec_max(from_lb(h1), from_lb(lb_rdata));
`else
  assign hval   = vec_max(cur, prev);
  assign pooled = vec_max(h1, lb_rdata);
`endif

  // The same pointer reads the stored row and overwrites it with this row's horizontal result.
  pool_line_buffer #(
    .DEPTH (MAX_ROW_VEC),
    .WIDTH (LANES * LB_W)
  ) u_line_buffer (
    .clk   (clk),
    .we    (acc && lb_wr),
    .waddr (ptr),
    .wdata (hval),
    .re    (acc && lb_wr),
    .raddr (ptr),
    .rdata (lb_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      v1    <= 1'b0;
      last1 <= 1'b0;
    end else if (en) begin
      v1    <= acc && emit;
      last1 <= acc && last_out;
    end
  end

  always_ff @(posedge clk) begin
    if (en)
      h1 <= hval;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mv    <= 1'b0;
      md    <= '0;
      last2 <= 1'b0;
    end else if (en) begin
      mv    <= v1;
      last2 <= v1 && last1;
      if (v1)
        md <= pooled;
    end
  end

  assign s.ready    = en;
  assign m.valid    = mv;
  assign m.data     = md;
  assign frame_done = mv && m.ready && last2;

  always_ff @(posedge clk) begin
    if (!rst && s.valid) begin
      assert (32'(cfg_ch_vec) <= 32'(MAX_CH_VEC) &&
              32'(cfg_width) * 32'(cfg_ch_vec) <= 32'(MAX_ROW_VEC))
        else $error("pool2d_stream: configuration exceeds buffer depth");
    end
  end
endmodule

// File: tb/tb_pool2d_stream.sv
// Directed bench for pool2d_stream: stride 2/1 pooling, signed ties, backpressure,
// mid-frame reset and back-to-back frames (average path when POOL_AVG_EN is defined).
module tb_pool2d_stream;
  logic        clk;
  logic        rst;
  logic [15:0] cfg_width;
  logic [15:0] cfg_height;
  logic [7:0]  cfg_ch_vec;
  logic        cfg_stride2;
`ifdef POOL_AVG_EN
  logic        cfg_avg;
`endif
  logic        frame_done;

  pool2d_stream_if #(.WIDTH(64)) s_if ();
  pool2d_stream_if #(.WIDTH(64)) m_if ();

  pool2d_stream dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_width   (cfg_width),
    .cfg_height  (cfg_height),
    .cfg_ch_vec  (cfg_ch_vec),
    .cfg_stride2 (cfg_stride2),
`ifdef POOL_AVG_EN
    .cfg_avg     (cfg_avg),
`endif
    .s           (s_if),
    .m           (m_if),
    .frame_done  (frame_done)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  int          fd_count = 0;
  int          fd_viol = 0;
  int          stall_viol = 0;
  bit          rand_ready = 0;
  bit          prev_stall = 0;
  logic [63:0] prev_data = '0;
  logic [63:0] frame_in [0:255];
  logic [63:0] got_q [$];
  logic [63:0] exp_q [$];

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    m_if.ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_if.ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Records accepted outputs, frame_done pulses and any change of m_data while stalled.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (prev_stall && (!m_if.valid || m_if.data !== prev_data))
          stall_viol++;
        if (m_if.valid && m_if.ready)
          got_q.push_back(m_if.data);
        if (frame_done) begin
          fd_count++;
          if (!(m_if.valid && m_if.ready))
            fd_viol++;
        end
        prev_stall = m_if.valid && !m_if.ready;
        prev_data  = m_if.data;
      end else begin
        prev_stall = 0;
      end
    end
  end

  function automatic logic [63:0] splat(input int v);
    logic [63:0] r;
    for (int l = 0; l < 8; l++)
      r[l*8 +: 8] = 8'(v);
    return r;
  endfunction

  task automatic set_cfg(input int w, input int h, input int c, input bit s2);
    cfg_width   = 16'(w);
    cfg_height  = 16'(h);
    cfg_ch_vec  = 8'(c);
    cfg_stride2 = s2;
  endtask

  task automatic clear_obs();
    got_q.delete();
    fd_count   = 0;
    fd_viol    = 0;
    stall_viol = 0;
  endtask

  task automatic drive_frame(input int w, input int h, input int c, input bit rand_valid,
                             input int limit, input int base);
    int idx = 0;
    int cyc = 0;
    int n;
    bit fire;
    n = w * h * c;
    if (limit < n) n = limit;
    while (idx < n && cyc < 5000) begin
      s_if.valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      s_if.data  = frame_in[base + idx];
      @(negedge clk);
      fire = s_if.valid && s_if.ready;
      @(posedge clk);
      #1;
      if (fire) idx++;
      cyc++;
    end
    s_if.valid = 1'b0;
    n_cmp++;
    if (idx < n) begin
      n_err++;
      $display("[TB] FAIL drive_timeout: accepted %0d beats, required %0d", idx, n);
    end
  endtask

  task automatic wait_outputs(input int n);
    int cyc = 0;
    while (got_q.size() < n && cyc < 2000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    repeat (6) @(posedge clk);
    #1;
  endtask

  // Independent window reference: lane-wise max over each 2x2 input window.
  task automatic build_expected(input int w, input int h, input int c, input bit s2);
    int          step;
    int          best;
    int          lv;
    logic [63:0] v;
    logic [63:0] px;
    step = s2 ? 2 : 1;
    exp_q.delete();
    for (int r = 1; r < h; r += step)
      for (int cl = 1; cl < w; cl += step)
        for (int ch = 0; ch < c; ch++) begin
          v = '0;
          for (int l = 0; l < 8; l++) begin
            best = -128;
            for (int dr = 0; dr < 2; dr++)
              for (int dc = 0; dc < 2; dc++) begin
                px = frame_in[((r - dr) * w + (cl - dc)) * c + ch];
                lv = int'($signed(px[l*8 +: 8]));
                if (lv > best) best = lv;
              end
            v[l*8 +: 8] = 8'(best);
          end
          exp_q.push_back(v);
        end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    s_if.valid = 1'b0;
    s_if.data  = '0;
    set_cfg(4, 4, 1, 1);
`ifdef POOL_AVG_EN
    cfg_avg = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (m_if.valid !== 1'b0) begin
      n_err++; $display("[TB] FAIL reset_m_valid: got %b, want 0", m_if.valid);
    end
    n_cmp++;
    if (m_if.data !== 64'd0) begin
      n_err++; $display("[TB] FAIL reset_m_data: got %h, want 0", m_if.data);
    end
    n_cmp++;
    if (frame_done !== 1'b0) begin
      n_err++; $display("[TB] FAIL reset_frame_done: got %b, want 0", frame_done);
    end
    n_cmp++;
    if (s_if.ready !== 1'b1) begin
      n_err++; $display("[TB] FAIL reset_s_ready: got %b, want 1", s_if.ready);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_stride2_ramp();
    logic [63:0] want [4];
    want[0] = splat(5); want[1] = splat(7); want[2] = splat(13); want[3] = splat(15);
    for (int i = 0; i < 16; i++) frame_in[i] = splat(i);
    set_cfg(4, 4, 1, 1);
    clear_obs();
    drive_frame(4, 4, 1, 0, 1000, 0);
    wait_outputs(4);
    n_cmp++;
    if (got_q.size() !== 4) begin
      n_err++; $display("[TB] FAIL ramp_count: got %0d, want 4", got_q.size());
    end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== want[i]) begin
        n_err++; $display("[TB] FAIL ramp_out%0d: got %h, want %h", i, got_q[i], want[i]);
      end
    end
    n_cmp++;
    if (fd_count !== 1) begin
      n_err++; $display("[TB] FAIL ramp_frame_done: got %0d pulses, want 1", fd_count);
    end
  endtask

  task automatic test_stride1_random();
    for (int i = 0; i < 18; i++) frame_in[i] = {$urandom, $urandom};
    set_cfg(3, 3, 2, 0);
    build_expected(3, 3, 2, 0);
    clear_obs();
    drive_frame(3, 3, 2, 0, 1000, 0);
    wait_outputs(8);
    n_cmp++;
    if (got_q.size() !== 8) begin
      n_err++; $display("[TB] FAIL s1_count: got %0d, want 8", got_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++; $display("[TB] FAIL s1_out%0d: got %h, want %h", i, got_q[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (fd_count !== 1) begin
      n_err++; $display("[TB] FAIL s1_frame_done: got %0d pulses, want 1", fd_count);
    end
  endtask

  task automatic test_signed_max();
    int          k;
    logic [63:0] v;
    for (int r = 0; r < 4; r++)
      for (int cl = 0; cl < 4; cl++)
        for (int ch = 0; ch < 8; ch++) begin
          for (int l = 0; l < 8; l++)
            v[l*8 +: 8] = (((r % 2) * 2 + (cl % 2)) == ((l + ch) % 5)) ? 8'hFF : 8'h80;
          frame_in[(r * 4 + cl) * 8 + ch] = v;
        end
    set_cfg(4, 4, 8, 1);
    clear_obs();
    drive_frame(4, 4, 8, 0, 1000, 0);
    wait_outputs(32);
    n_cmp++;
    if (got_q.size() !== 32) begin
      n_err++; $display("[TB] FAIL signed_count: got %0d, want 32", got_q.size());
    end
    for (int i = 0; i < 32 && i < got_q.size(); i++) begin
      k = i % 8;
      for (int l = 0; l < 8; l++)
        v[l*8 +: 8] = (((l + k) % 5) != 4) ? 8'hFF : 8'h80;
      n_cmp++;
      if (got_q[i] !== v) begin
        n_err++; $display("[TB] FAIL signed_out%0d: got %h, want %h", i, got_q[i], v);
      end
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 75; i++) frame_in[i] = {$urandom, $urandom};
    set_cfg(5, 5, 3, 1);
    build_expected(5, 5, 3, 1);
    clear_obs();
    rand_ready = 1;
    drive_frame(5, 5, 3, 1, 1000, 0);
    wait_outputs(12);
    rand_ready = 0;
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if (got_q.size() !== 12) begin
      n_err++; $display("[TB] FAIL bp_count: got %0d, want 12", got_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++; $display("[TB] FAIL bp_out%0d: got %h, want %h", i, got_q[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (stall_viol !== 0) begin
      n_err++; $display("[TB] FAIL bp_stall_hold: got %0d changes while stalled, want 0", stall_viol);
    end
    n_cmp++;
    if (fd_count !== 1 || fd_viol !== 0) begin
      n_err++; $display("[TB] FAIL bp_frame_done: got %0d pulses (%0d unaccepted), want 1 (0)", fd_count, fd_viol);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [63:0] want [4];
    want[0] = splat(105); want[1] = splat(107); want[2] = splat(113); want[3] = splat(115);
    for (int i = 0; i < 16; i++) frame_in[i] = splat(i);
    set_cfg(4, 4, 1, 1);
    clear_obs();
    drive_frame(4, 4, 1, 0, 10, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_obs();
    for (int i = 0; i < 16; i++) frame_in[i] = splat(100 + i);
    drive_frame(4, 4, 1, 0, 1000, 0);
    wait_outputs(4);
    n_cmp++;
    if (got_q.size() !== 4) begin
      n_err++; $display("[TB] FAIL rst_mid_count: got %0d, want 4", got_q.size());
    end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== want[i]) begin
        n_err++; $display("[TB] FAIL rst_mid_out%0d: got %h, want %h", i, got_q[i], want[i]);
      end
    end
    n_cmp++;
    if (fd_count !== 1) begin
      n_err++; $display("[TB] FAIL rst_mid_frame_done: got %0d pulses, want 1", fd_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] want [2];
    frame_in[0] = splat(1);  frame_in[1] = splat(2);  frame_in[2] = splat(3);  frame_in[3] = splat(4);
    frame_in[4] = splat(-1); frame_in[5] = splat(-2); frame_in[6] = splat(-2); frame_in[7] = splat(-2);
`ifdef POOL_AVG_EN
    cfg_avg = 1'b1;
    want[0] = splat(3);
    want[1] = splat(-2);
`else
    want[0] = splat(4);
    want[1] = splat(-1);
`endif
    set_cfg(2, 2, 1, 1);
    clear_obs();
    drive_frame(2, 2, 1, 0, 1000, 0);
    drive_frame(2, 2, 1, 0, 1000, 4);
    wait_outputs(2);
    n_cmp++;
    if (got_q.size() !== 2) begin
      n_err++; $display("[TB] FAIL b2b_count: got %0d, want 2", got_q.size());
    end
    for (int i = 0; i < 2 && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== want[i]) begin
        n_err++; $display("[TB] FAIL b2b_out%0d: got %h, want %h", i, got_q[i], want[i]);
      end
    end
    n_cmp++;
    if (fd_count !== 2) begin
      n_err++; $display("[TB] FAIL b2b_frame_done: got %0d pulses, want 2", fd_count);
    end
  endtask

  initial begin
    test_reset();
    test_stride2_ramp();
    test_stride1_random();
    test_signed_max();
    test_backpressure();
    test_reset_mid_frame();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
